// File: rtl/alu_pkg.sv
// Shared ALU opcodes, widths and arbiter state encoding.
package alu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned SEL_W = 4;

    localparam logic [SEL_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [SEL_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [SEL_W-1:0] ALU_PASS = 4'd2;
    localparam logic [SEL_W-1:0] ALU_SLL  = 4'd3;
    localparam logic [SEL_W-1:0] ALU_SRL  = 4'd4;
    localparam logic [SEL_W-1:0] ALU_SRA  = 4'd5;
    localparam logic [SEL_W-1:0] ALU_XOR  = 4'd6;
    localparam logic [SEL_W-1:0] ALU_OR   = 4'd7;
    localparam logic [SEL_W-1:0] ALU_AND  = 4'd8;
    localparam logic [SEL_W-1:0] ALU_SLT  = 4'd9;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Shift ops take their amount from op2[4:0] only.
    function automatic logic is_shift(input logic [SEL_W-1:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters and the ALU arbiter.
interface alu_arbiter_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned SEL_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [XLEN-1:0]  req0_op1;
    logic [XLEN-1:0]  req0_op2;
    logic [SEL_W-1:0] req0_sel;
    logic             req1_valid;
    logic             req1_ready;
    logic [XLEN-1:0]  req1_op1;
    logic [XLEN-1:0]  req1_op2;
    logic [SEL_W-1:0] req1_sel;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [XLEN-1:0]  rsp_res;
    logic             rsp_zero;
    logic             rsp_illegal;
    logic             busy;

    // Requester side.
    modport master (
        output req0_valid, req0_op1, req0_op2, req0_sel,
        output req1_valid, req1_op1, req1_op2, req1_sel,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_res, rsp_zero, rsp_illegal, busy
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_op1, req0_op2, req0_sel,
        input  req1_valid, req1_op1, req1_op2, req1_sel,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_res, rsp_zero, rsp_illegal, busy
    );
endinterface

// File: rtl/alu_module.sv
// Combinational 32-bit ALU; shifts use the full op2, so callers mask it.
module alu_module
    import alu_pkg::*;
(
    input  logic [XLEN-1:0]  i_op1,
    input  logic [XLEN-1:0]  i_op2,
    input  logic [SEL_W-1:0] i_sel,
    output logic [XLEN-1:0]  o_res,
    output logic             o_illegal
);

    // Decode the operation; unknown selects yield zero and flag illegal.
    always_comb begin
        o_res     = '0;
        o_illegal = 1'b0;
        case (i_sel)
            ALU_ADD:  o_res = i_op1 + i_op2;
            ALU_SUB:  o_res = i_op1 - i_op2;
            ALU_PASS: o_res = i_op2;
            ALU_SLL:  o_res = i_op1 << i_op2;
            ALU_SRL:  o_res = i_op1 >> i_op2;
            ALU_SRA:  o_res = $unsigned($signed(i_op1) >>> i_op2);
            ALU_XOR:  o_res = i_op1 ^ i_op2;
            ALU_OR:   o_res = i_op1 | i_op2;
            ALU_AND:  o_res = i_op1 & i_op2;
            ALU_SLT:  o_res = {{(XLEN-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single ALU with a one-entry issue register.
module alu_arbiter #(
    parameter int unsigned XLEN  = alu_pkg::XLEN,
    parameter int unsigned SEL_W = alu_pkg::SEL_W,
    parameter bit          FAIR  = 1'b1
) (
    input logic         clk,
    input logic         rst,
    alu_arbiter_if.slave bus
);
    import alu_pkg::*;

    state_e           r_state;
    state_e           w_state_next;
    logic [XLEN-1:0]  r_op1;
    logic [XLEN-1:0]  r_op2;
    logic [SEL_W-1:0] r_sel;
    logic             r_owner;
    logic             r_ptr;

    logic             w_drain;
    logic             w_can_issue;
    logic             w_grant;
    logic             w_gnt_id;
    logic [XLEN-1:0]  w_alu_op2;
    logic [XLEN-1:0]  w_alu_res;
    logic             w_alu_illegal;

    // Pick a winner; a new grant is possible when empty or when the held
    // result is being consumed this cycle.
    always_comb begin
        w_drain     = (r_state == ST_FULL) && (r_owner ? bus.rsp1_ready : bus.rsp0_ready);
        w_can_issue = (r_state == ST_EMPTY) || w_drain;
        w_gnt_id    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_gnt_id = FAIR ? r_ptr : 1'b0;
        end else if (bus.req1_valid) begin
            w_gnt_id = 1'b1;
        end
        w_grant = w_can_issue && (bus.req0_valid || bus.req1_valid);
    end

    // Next-state: back-to-back grants keep the entry full.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_grant) w_state_next = ST_FULL;
            ST_FULL: begin
                if (w_grant) begin
                    w_state_next = ST_FULL;
                end else if (w_drain) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default:  w_state_next = ST_EMPTY;
        endcase
    end

    // State, issue register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_op1   <= '0;
            r_op2   <= '0;
            r_sel   <= '0;
            r_owner <= 1'b0;
            r_ptr   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_op1   <= w_gnt_id ? bus.req1_op1 : bus.req0_op1;
                r_op2   <= w_gnt_id ? bus.req1_op2 : bus.req0_op2;
                r_sel   <= w_gnt_id ? bus.req1_sel : bus.req0_sel;
                r_owner <= w_gnt_id;
                r_ptr   <= ~w_gnt_id;
            end
        end
    end

    // Only the low five bits of op2 reach the ALU for shifts.
    always_comb begin
        w_alu_op2 = r_op2;
        if (is_shift(r_sel)) begin
            w_alu_op2 = {{(XLEN-5){1'b0}}, r_op2[4:0]};
        end
    end

    alu_module u_alu (
        .i_op1     (r_op1),
        .i_op2     (w_alu_op2),
        .i_sel     (r_sel),
        .o_res     (w_alu_res),
        .o_illegal (w_alu_illegal)
    );

    // Handshake and result outputs; the zero flag compares the raw operands.
    always_comb begin
        bus.req0_ready  = w_grant && !w_gnt_id;
        bus.req1_ready  = w_grant && w_gnt_id;
        bus.rsp0_valid  = (r_state == ST_FULL) && !r_owner;
        bus.rsp1_valid  = (r_state == ST_FULL) && r_owner;
        bus.rsp_res     = w_alu_res;
        bus.rsp_zero    = (r_op1 == r_op2);
        bus.rsp_illegal = w_alu_illegal;
        bus.busy        = (r_state == ST_FULL);
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: scoreboard of expected responses.
`timescale 1ns/1ps
module tb_alu_arbiter;

    typedef struct packed {
        logic        port;
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_arbiter_if #(.XLEN(32), .SEL_W(4)) bus_f ();
    alu_arbiter_if #(.XLEN(32), .SEL_W(4)) bus_x ();

    alu_arbiter #(.XLEN(32), .SEL_W(4), .FAIR(1'b1)) u_fair (
        .clk (clk),
        .rst (rst),
        .bus (bus_f)
    );

    alu_arbiter #(.XLEN(32), .SEL_W(4), .FAIR(1'b0)) u_fixed (
        .clk (clk),
        .rst (rst),
        .bus (bus_x)
    );

    function automatic exp_t alu_ref(input logic port, input logic [3:0] sel,
                                     input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.port = port;
        e.res  = 32'd0;
        e.ill  = 1'b0;
        e.zero = (a == b);
        case (sel)
            4'd0: e.res = a + b;
            4'd1: e.res = a - b;
            4'd2: e.res = b;
            4'd3: e.res = a << b[4:0];
            4'd4: e.res = a >> b[4:0];
            4'd5: e.res = $unsigned($signed(a) >>> b[4:0]);
            4'd6: e.res = a ^ b;
            4'd7: e.res = a | b;
            4'd8: e.res = a & b;
            4'd9: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic idle_inputs();
        bus_f.req0_valid = 0; bus_f.req0_op1 = 0; bus_f.req0_op2 = 0; bus_f.req0_sel = 0;
        bus_f.req1_valid = 0; bus_f.req1_op1 = 0; bus_f.req1_op2 = 0; bus_f.req1_sel = 0;
        bus_f.rsp0_ready = 0; bus_f.rsp1_ready = 0;
        bus_x.req0_valid = 0; bus_x.req0_op1 = 0; bus_x.req0_op2 = 0; bus_x.req0_sel = 0;
        bus_x.req1_valid = 0; bus_x.req1_op1 = 0; bus_x.req1_op2 = 0; bus_x.req1_sel = 0;
        bus_x.rsp0_ready = 0; bus_x.rsp1_ready = 0;
    endtask

    // Leaves the DUTs out of reset, 1 ns after a rising edge.
    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (bus_f.rsp0_valid !== 1'b0 || bus_f.rsp1_valid !== 1'b0 || bus_f.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids got rsp0=%b rsp1=%b busy=%b expected 0 0 0",
                     bus_f.rsp0_valid, bus_f.rsp1_valid, bus_f.busy);
        end
        checks++;
        if (bus_f.rsp_res !== 32'd0 || bus_f.rsp_zero !== 1'b1 || bus_f.rsp_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_result got res=%h zero=%b ill=%b expected 0 1 0",
                     bus_f.rsp_res, bus_f.rsp_zero, bus_f.rsp_illegal);
        end
        checks++;
        if (bus_f.req0_ready !== 1'b0 || bus_f.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b%b expected 00", bus_f.req0_ready, bus_f.req1_ready);
        end
    endtask

    task automatic test_single_add();
        exp_t e;
        apply_reset();
        bus_f.req0_valid = 1; bus_f.req0_sel = 4'd0;
        bus_f.req0_op1 = 32'd6; bus_f.req0_op2 = 32'd5; bus_f.rsp0_ready = 1;
        @(negedge clk);
        checks++;
        if ({bus_f.req0_ready, bus_f.req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL add_grant got %b%b expected 10", bus_f.req0_ready, bus_f.req1_ready);
        end
        sb.push_back(alu_ref(1'b0, 4'd0, 32'd6, 32'd5));
        @(posedge clk); #1 bus_f.req0_valid = 0;
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL add_sb got empty scoreboard expected one entry");
        end else begin
            e = sb.pop_front();
            if ({bus_f.rsp0_valid, bus_f.rsp1_valid} !== 2'b10 || bus_f.rsp_res !== e.res ||
                bus_f.rsp_zero !== e.zero || bus_f.rsp_illegal !== e.ill) begin
                errors++;
                $display("FAIL add_rsp got v=%b%b res=%h z=%b ill=%b expected v=10 res=%h z=%b ill=%b",
                         bus_f.rsp0_valid, bus_f.rsp1_valid, bus_f.rsp_res, bus_f.rsp_zero,
                         bus_f.rsp_illegal, e.res, e.zero, e.ill);
            end
        end
        @(posedge clk); #1 bus_f.rsp0_ready = 0;
    endtask

    task automatic test_round_robin();
        exp_t e;
        logic g;
        apply_reset();
        bus_f.req0_valid = 1; bus_f.req0_sel = 4'd1; bus_f.req0_op1 = 32'd7; bus_f.req0_op2 = 32'd7;
        bus_f.req1_valid = 1; bus_f.req1_sel = 4'd6;
        bus_f.req1_op1 = 32'hF0; bus_f.req1_op2 = 32'h0F;
        bus_f.rsp0_ready = 1; bus_f.rsp1_ready = 1;
        for (int k = 0; k < 9; k++) begin
            if (k == 8) begin
                bus_f.req0_valid = 0; bus_f.req1_valid = 0;
            end
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rr_sb cycle %0d got empty scoreboard expected entry", k);
                end else begin
                    e = sb.pop_front();
                    if ({bus_f.rsp0_valid, bus_f.rsp1_valid} !== {!e.port, e.port} ||
                        bus_f.rsp_res !== e.res || bus_f.rsp_zero !== e.zero) begin
                        errors++;
                        $display("FAIL rr_rsp cycle %0d got v=%b%b res=%h z=%b expected port=%0d res=%h z=%b",
                                 k, bus_f.rsp0_valid, bus_f.rsp1_valid, bus_f.rsp_res,
                                 bus_f.rsp_zero, e.port, e.res, e.zero);
                    end
                end
            end
            if (k < 8) begin
                g = k[0];
                checks++;
                if ({bus_f.req0_ready, bus_f.req1_ready} !== {!g, g}) begin
                    errors++;
                    $display("FAIL rr_grant cycle %0d got %b%b expected port %0d",
                             k, bus_f.req0_ready, bus_f.req1_ready, g);
                end
                if (g) sb.push_back(alu_ref(1'b1, 4'd6, 32'hF0, 32'h0F));
                else   sb.push_back(alu_ref(1'b0, 4'd1, 32'd7, 32'd7));
            end
            @(posedge clk); #1;
        end
        bus_f.rsp0_ready = 0; bus_f.rsp1_ready = 0;
    endtask

    task automatic test_backpressure();
        exp_t e;
        apply_reset();
        bus_f.req1_valid = 1; bus_f.req1_sel = 4'd5;
        bus_f.req1_op1 = 32'h8000_0000; bus_f.req1_op2 = 32'd4;
        @(negedge clk);
        checks++;
        if (bus_f.req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_grant got req1_ready=%b expected 1", bus_f.req1_ready);
        end
        sb.push_back(alu_ref(1'b1, 4'd5, 32'h8000_0000, 32'd4));
        @(posedge clk); #1;
        bus_f.req1_valid = 0;
        bus_f.req0_valid = 1; bus_f.req0_sel = 4'd0; bus_f.req0_op1 = 32'd6; bus_f.req0_op2 = 32'd5;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({bus_f.rsp1_valid, bus_f.req0_ready, bus_f.req1_ready, bus_f.rsp_res} !==
                {3'b100, 32'hF800_0000}) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got v1=%b rdy=%b%b res=%h expected 1 00 f8000000",
                         k, bus_f.rsp1_valid, bus_f.req0_ready, bus_f.req1_ready, bus_f.rsp_res);
            end
            @(posedge clk); #1;
        end
        bus_f.rsp1_ready = 1; bus_f.rsp0_ready = 1;
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL bp_sb got empty scoreboard expected entry");
        end else begin
            e = sb.pop_front();
            if (bus_f.rsp1_valid !== 1'b1 || bus_f.rsp_res !== e.res || bus_f.rsp_zero !== e.zero) begin
                errors++;
                $display("FAIL bp_rsp got v1=%b res=%h z=%b expected 1 %h %b",
                         bus_f.rsp1_valid, bus_f.rsp_res, bus_f.rsp_zero, e.res, e.zero);
            end
        end
        checks++;
        if (bus_f.req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_b2b got req0_ready=%b expected 1", bus_f.req0_ready);
        end
        sb.push_back(alu_ref(1'b0, 4'd0, 32'd6, 32'd5));
        @(posedge clk); #1 bus_f.req0_valid = 0; bus_f.rsp1_ready = 0;
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL bp_sb2 got empty scoreboard expected entry");
        end else begin
            e = sb.pop_front();
            if (bus_f.rsp0_valid !== 1'b1 || bus_f.rsp_res !== e.res) begin
                errors++;
                $display("FAIL bp_rsp2 got v0=%b res=%h expected 1 %h",
                         bus_f.rsp0_valid, bus_f.rsp_res, e.res);
            end
        end
        @(posedge clk); #1 bus_f.rsp0_ready = 0;
    endtask

    task automatic test_fixed_priority();
        apply_reset();
        bus_x.req0_valid = 1; bus_x.req0_sel = 4'd0; bus_x.req0_op1 = 32'd1; bus_x.req0_op2 = 32'd2;
        bus_x.req1_valid = 1; bus_x.req1_sel = 4'd0; bus_x.req1_op1 = 32'd3; bus_x.req1_op2 = 32'd4;
        bus_x.rsp0_ready = 1; bus_x.rsp1_ready = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({bus_x.req0_ready, bus_x.req1_ready, bus_x.rsp1_valid} !== 3'b100) begin
                errors++;
                $display("FAIL fixed_grant cycle %0d got rdy=%b%b v1=%b expected 10 0",
                         k, bus_x.req0_ready, bus_x.req1_ready, bus_x.rsp1_valid);
            end
            if (k > 0) begin
                checks++;
                if (bus_x.rsp0_valid !== 1'b1 || bus_x.rsp_res !== 32'd3) begin
                    errors++;
                    $display("FAIL fixed_rsp cycle %0d got v0=%b res=%h expected 1 3",
                             k, bus_x.rsp0_valid, bus_x.rsp_res);
                end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_illegal_shift();
        exp_t e;
        apply_reset();
        bus_f.req0_valid = 1; bus_f.req0_sel = 4'd12; bus_f.req0_op1 = 32'd3; bus_f.req0_op2 = 32'd4;
        bus_f.rsp0_ready = 1;
        @(negedge clk);
        sb.push_back(alu_ref(1'b0, 4'd12, 32'd3, 32'd4));
        @(posedge clk); #1;
        bus_f.req0_sel = 4'd3; bus_f.req0_op1 = 32'd1; bus_f.req0_op2 = 32'h21;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (bus_f.req0_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ill_b2b got req0_ready=%b expected 1", bus_f.req0_ready);
                end
                sb.push_back(alu_ref(1'b0, 4'd3, 32'd1, 32'h21));
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL ill_sb got empty scoreboard expected entry");
            end else begin
                e = sb.pop_front();
                if (bus_f.rsp0_valid !== 1'b1 || bus_f.rsp_res !== e.res ||
                    bus_f.rsp_illegal !== e.ill || bus_f.rsp_zero !== e.zero) begin
                    errors++;
                    $display("FAIL ill_rsp%0d got v0=%b res=%h ill=%b z=%b expected 1 %h %b %b",
                             k, bus_f.rsp0_valid, bus_f.rsp_res, bus_f.rsp_illegal,
                             bus_f.rsp_zero, e.res, e.ill, e.zero);
                end
            end
            @(posedge clk); #1 bus_f.req0_valid = 0;
        end
        @(negedge clk);
        checks++;
        if (bus_f.busy !== 1'b0) begin
            errors++;
            $display("FAIL ill_done got busy=%b expected 0", bus_f.busy);
        end
        @(posedge clk); #1 bus_f.rsp0_ready = 0;
    endtask

    task automatic test_reset_mid_op();
        exp_t e;
        apply_reset();
        bus_f.req0_valid = 1; bus_f.req0_sel = 4'd0; bus_f.req0_op1 = 32'd10; bus_f.req0_op2 = 32'd20;
        @(posedge clk); #1 bus_f.req0_valid = 0;
        @(negedge clk);
        checks++;
        if (bus_f.busy !== 1'b1 || bus_f.rsp0_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_full got busy=%b v0=%b expected 1 1", bus_f.busy, bus_f.rsp0_valid);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (bus_f.busy !== 1'b0 || bus_f.rsp0_valid !== 1'b0 || bus_f.rsp_res !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b v0=%b res=%h expected 0 0 0",
                     bus_f.busy, bus_f.rsp0_valid, bus_f.rsp_res);
        end
        @(posedge clk); #1;
        bus_f.req0_valid = 1; bus_f.req0_sel = 4'd0; bus_f.req0_op1 = 32'd6; bus_f.req0_op2 = 32'd5;
        bus_f.req1_valid = 1; bus_f.req1_sel = 4'd2; bus_f.req1_op1 = 32'd0; bus_f.req1_op2 = 32'd9;
        bus_f.rsp0_ready = 1;
        @(negedge clk);
        checks++;
        if ({bus_f.req0_ready, bus_f.req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL mid_ptr got %b%b expected 10", bus_f.req0_ready, bus_f.req1_ready);
        end
        sb.push_back(alu_ref(1'b0, 4'd0, 32'd6, 32'd5));
        @(posedge clk); #1 bus_f.req0_valid = 0; bus_f.req1_valid = 0;
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL mid_sb got empty scoreboard expected entry");
        end else begin
            e = sb.pop_front();
            if (bus_f.rsp0_valid !== 1'b1 || bus_f.rsp_res !== e.res || bus_f.rsp_zero !== e.zero) begin
                errors++;
                $display("FAIL mid_rsp got v0=%b res=%h z=%b expected 1 %h %b",
                         bus_f.rsp0_valid, bus_f.rsp_res, bus_f.rsp_zero, e.res, e.zero);
            end
        end
        @(posedge clk); #1 bus_f.rsp0_ready = 0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_round_robin();
        test_backpressure();
        test_fixed_priority();
        test_illegal_shift();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish expected finish within 200000 ns");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational alu_module between two requesters: port 0 (execute stage) and port 1 (branch/address-generation unit).
- Arbitrates with round-robin or fixed priority and latches the winning operands into an issue register.
- Presents the registered ALU result with valid/ready handshakes on a per-requester response port.
- Sits between decode/execute and the single ALU instance.

Parameters:
- XLEN, 32, operand/result width; must be 32, the alu_module width.
- SEL_W, 4, width of the ALU operation select.
- FAIR, 1, 1 = round-robin arbitration, 0 = fixed priority (port 0 always wins).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- req0_valid / req1_valid  in  1  request valid.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready.
- req0_op1, req0_op2, req1_op1, req1_op2  in  XLEN  operands.
- req0_sel / req1_sel  in  SEL_W  ALU op: 0 add, 1 sub, 2 pass op2, 3 sll, 4 srl, 5 sra, 6 xor, 7 or, 8 and, 9 slt.
- rsp0_valid / rsp1_valid  out  1  result valid for that requester.
- rsp0_ready / rsp1_ready  in  1  requester consumes the result.
- rsp_res  out  XLEN  result; shared bus, qualified by rspN_valid.
- rsp_zero  out  1  ALU zero flag (op1 == op2).
- rsp_illegal  out  1  sel > 9; rsp_res is 0 in that case.
- busy  out  1  issue register occupied.

Behaviour:
- Reset: every state register clears. Outputs after reset:
  - rsp0_valid, rsp1_valid, busy, rsp_illegal: 0.
  - rsp_res: 0; rsp_zero: 1 (zeroed operands compare equal).
  - Round-robin pointer = 0, so port 0 has priority first.
- States:
  - EMPTY: issue register free.
  - FULL: holds operands, sel, owner id; ALU output is valid.
- EMPTY:
  - If any reqN_valid, grant one requester. The grant asserts that port's reqN_ready combinationally in the same cycle.
  - Latch op1, op2, sel and owner; go to FULL. The other ready stays 0.
- FULL:
  - The ALU is driven from the issue register. rsp_res, rsp_zero and rsp_illegal are stable the whole time in FULL.
  - rsp{owner}_valid = 1; the other rsp valid = 0.
  - On rsp{owner}_ready = 1: if a request is valid this cycle, grant it (back-to-back issue) and stay FULL with the new contents. Otherwise go to EMPTY.
  - Without rsp ready, both req_ready = 0 and the contents hold indefinitely.
- Latency: 1 cycle from request accept to rspN_valid. Full throughput is one op per cycle when the consumer is always ready.
- Arbitration when FAIR=1:
  - If both requests are valid, the pointer port wins.
  - After each grant, the pointer moves to the non-granted port.
  - A single valid request always wins, whatever the pointer says.
- Arbitration when FAIR=0: port 0 always wins when valid.
- Input operands are sampled only on a grant. Changes to an ungranted request's inputs have no effect.
- A requester must hold valid/operands stable until it sees ready. The arbiter does not check this.
- Shifts use op2[4:0]; upper op2 bits are ignored. This matches RV32 semantics and requires masking before the ALU.
- sel 10..15: result 0, rsp_illegal = 1, handshake proceeds normally (no hang).
- Reset mid-operation: a FULL entry is discarded without producing a response. The owner must re-issue.

Decomposition:
- Shared package alu_pkg: ALU sel localparams (ALU_ADD=0 … ALU_SLT=9), SEL_W, XLEN, state encoding (ST_EMPTY, ST_FULL).
- Sub-module: one instance of the existing alu_module, fed from the issue register. No other sub-module.

Test Plan:
- Reset, then idle: rsp0_valid = rsp1_valid = busy = 0, rsp_res = 0. Then req0: add, op1=6, op2=5 -> req0_ready in cycle 0; cycle 1: rsp0_valid=1, rsp_res=11, rsp_zero=0.
- Both valid every cycle, FAIR=1, rsp ready tied 1. req0 = sub 7−7, req1 = xor 0xF0^0x0F -> grants alternate 0,1,0,1. Port 0 results: res 0, zero 1. Port 1 results: res 0xFF.
- Backpressure: req1 sra op1=0x80000000, op2=4; hold rsp1_ready=0 for 5 cycles -> rsp_res = 0xF8000000 stable, both req_ready = 0. Release -> accepted, next request granted the same cycle.
- FAIR=0 with both valid continuously -> port 0 granted every cycle; port 1 starves (expected).
- Illegal sel=12, op1=3, op2=4 -> rsp_res = 0, rsp_illegal = 1, handshake completes. Shift case: sll op1=1, op2=0x21 -> rsp_res = 2 (shift by op2[4:0] = 1).
- rst asserted while FULL with rsp0_ready=0 -> next cycle busy = 0, rsp0_valid = 0, pointer = 0. Re-issued req0 completes normally.
